// File: rtl/rv_mul_pipe.sv
// Pipelined RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with stall and flush.
// Stage 1 holds four half-width partial products; the last stage sums them and selects the product half.
module rv_mul_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ce_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [1:0]      funct_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            ce_o,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned PW   = XLEN + 2;
    localparam int unsigned W2   = 2 * XLEN;
    localparam int unsigned NPP  = (STAGES > 1) ? STAGES - 1 : 1;

    if (!((XLEN == 32 || XLEN == 64) && STAGES >= 1 && STAGES <= 4)) begin : g_bad_param
        $error("rv_mul_pipe: illegal XLEN/STAGES combination");
    end

    logic            sign_a;
    logic            sign_b;
    logic [XLEN:0]   a_ext;
    logic [XLEN:0]   b_ext;
    logic [PW-1:0]   a_lo_x;
    logic [PW-1:0]   a_hi_x;
    logic [PW-1:0]   b_lo_x;
    logic [PW-1:0]   b_hi_x;
    logic [PW-1:0]   pp_ll;
    logic [PW-1:0]   pp_lh;
    logic [PW-1:0]   pp_hl;
    logic [PW-1:0]   pp_hh;
    logic            vld_out;
    logic [XLEN-1:0] res_q;

    // Operands become signed (XLEN+1)-bit values split into an unsigned low half and
    // a signed high part; each PW-bit product is exact, so plain modular multiply suffices.
    always_comb begin
        sign_a = (funct_i == 2'b01) || (funct_i == 2'b10);
        sign_b = (funct_i == 2'b01);
        a_ext  = {sign_a & op1_i[XLEN-1], op1_i};
        b_ext  = {sign_b & op2_i[XLEN-1], op2_i};
        a_lo_x = {{(HALF+2){1'b0}}, a_ext[HALF-1:0]};
        a_hi_x = {{(HALF+1){a_ext[XLEN]}}, a_ext[XLEN:HALF]};
        b_lo_x = {{(HALF+2){1'b0}}, b_ext[HALF-1:0]};
        b_hi_x = {{(HALF+1){b_ext[XLEN]}}, b_ext[XLEN:HALF]};
        pp_ll  = a_lo_x * b_lo_x;
        pp_lh  = a_lo_x * b_hi_x;
        pp_hl  = a_hi_x * b_lo_x;
        pp_hh  = a_hi_x * b_hi_x;
    end

    function automatic logic [W2-1:0] sx(input logic [PW-1:0] v);
        return {{(XLEN-2){v[PW-1]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] sum_select(input logic [PW-1:0] ll, input logic [PW-1:0] lh,
                                                   input logic [PW-1:0] hl, input logic [PW-1:0] hh,
                                                   input logic [1:0] f);
        logic [W2-1:0] p;
        p = sx(ll) + (sx(lh) << HALF) + (sx(hl) << HALF) + (sx(hh) << XLEN);
        return (f == 2'b00) ? p[XLEN-1:0] : p[W2-1:XLEN];
    endfunction

    if (STAGES == 1) begin : g_one
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_out <= 1'b0;
                res_q   <= '0;
            end else if (flush_i) begin
                vld_out <= 1'b0;
            end else if (!stall_i) begin
                vld_out <= ce_i;
                if (ce_i) res_q <= sum_select(pp_ll, pp_lh, pp_hl, pp_hh, funct_i);
            end
        end
        assign busy_o = vld_out;
    end else begin : g_multi
        logic [NPP-1:0] vld_pp;
        logic [1:0]     fn_pp [NPP];
        logic [PW-1:0]  ll_pp [NPP];
        logic [PW-1:0]  lh_pp [NPP];
        logic [PW-1:0]  hl_pp [NPP];
        logic [PW-1:0]  hh_pp [NPP];

        // Data registers load only behind a valid bit so result_o holds between results.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_pp  <= '0;
                vld_out <= 1'b0;
                res_q   <= '0;
                for (int unsigned i = 0; i < NPP; i++) begin
                    fn_pp[i] <= '0;
                    ll_pp[i] <= '0;
                    lh_pp[i] <= '0;
                    hl_pp[i] <= '0;
                    hh_pp[i] <= '0;
                end
            end else if (flush_i) begin
                vld_pp  <= '0;
                vld_out <= 1'b0;
            end else if (!stall_i) begin
                vld_pp[0] <= ce_i;
                if (ce_i) begin
                    fn_pp[0] <= funct_i;
                    ll_pp[0] <= pp_ll;
                    lh_pp[0] <= pp_lh;
                    hl_pp[0] <= pp_hl;
                    hh_pp[0] <= pp_hh;
                end
                for (int unsigned i = 1; i < NPP; i++) begin
                    vld_pp[i] <= vld_pp[i-1];
                    if (vld_pp[i-1]) begin
                        fn_pp[i] <= fn_pp[i-1];
                        ll_pp[i] <= ll_pp[i-1];
                        lh_pp[i] <= lh_pp[i-1];
                        hl_pp[i] <= hl_pp[i-1];
                        hh_pp[i] <= hh_pp[i-1];
                    end
                end
                vld_out <= vld_pp[NPP-1];
                if (vld_pp[NPP-1]) begin
                    res_q <= sum_select(ll_pp[NPP-1], lh_pp[NPP-1], hl_pp[NPP-1],
                                        hh_pp[NPP-1], fn_pp[NPP-1]);
                end
            end
        end
        assign busy_o = (|vld_pp) | vld_out;
    end

    assign ce_o     = vld_out;
    assign result_o = res_q;

endmodule

// File: tb/tb_rv_mul_pipe.sv
// Directed self-checking bench for rv_mul_pipe: main 32-bit/2-stage instance plus
// 32-bit/1-stage, 32-bit/4-stage and 64-bit/2-stage instances driven in parallel.
module tb_rv_mul_pipe;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        stall;
    logic        flush;
    logic [1:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] op1_64;
    logic [63:0] op2_64;

    logic        ce_2, busy_2, ce_1, busy_1, ce_4, busy_4, ce_x, busy_x;
    logic [31:0] res_2, res_1, res_4;
    logic [63:0] res_x;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] got_q[$];

    rv_mul_pipe #(.XLEN(32), .STAGES(2)) u_s2 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .op1_i(op1), .op2_i(op2), .funct_i(funct),
        .stall_i(stall), .flush_i(flush), .ce_o(ce_2), .result_o(res_2), .busy_o(busy_2));
    rv_mul_pipe #(.XLEN(32), .STAGES(1)) u_s1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .op1_i(op1), .op2_i(op2), .funct_i(funct),
        .stall_i(stall), .flush_i(flush), .ce_o(ce_1), .result_o(res_1), .busy_o(busy_1));
    rv_mul_pipe #(.XLEN(32), .STAGES(4)) u_s4 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .op1_i(op1), .op2_i(op2), .funct_i(funct),
        .stall_i(stall), .flush_i(flush), .ce_o(ce_4), .result_o(res_4), .busy_o(busy_4));
    rv_mul_pipe #(.XLEN(64), .STAGES(2)) u_x64 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .op1_i(op1_64), .op2_i(op2_64), .funct_i(funct),
        .stall_i(stall), .flush_i(flush), .ce_o(ce_x), .result_o(res_x), .busy_o(busy_x));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string name, input logic [1:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] a64, input logic [63:0] b64,
                           input logic [31:0] e32, input logic [63:0] e64);
        funct = f; op1 = a; op2 = b; op1_64 = a64; op2_64 = b64; ce = 1'b1;
        tick();
        ce = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk({name, " s2 ce"}, 64'(ce_2), 64'(k == 2));
            chk({name, " s2 busy"}, 64'(busy_2), 64'(k <= 2));
            if (k == 2) chk({name, " s2 res"}, 64'(res_2), 64'(e32));
            chk({name, " s1 ce"}, 64'(ce_1), 64'(k == 1));
            chk({name, " s1 busy"}, 64'(busy_1), 64'(k <= 1));
            if (k == 1) chk({name, " s1 res"}, 64'(res_1), 64'(e32));
            chk({name, " s4 ce"}, 64'(ce_4), 64'(k == 4));
            chk({name, " s4 busy"}, 64'(busy_4), 64'(k <= 4));
            if (k == 4) chk({name, " s4 res"}, 64'(res_4), 64'(e32));
            chk({name, " x64 ce"}, 64'(ce_x), 64'(k == 2));
            if (k == 2) chk({name, " x64 res"}, res_x, e64);
            tick();
        end
    endtask

    task automatic cyc(input logic c, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic fl);
        ce = c; op1 = a; op2 = b; op1_64 = {32'h0, a}; op2_64 = {32'h0, b};
        stall = s; flush = fl;
        if (ce_2 && !stall) got_q.push_back(res_2);
        tick();
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; stall = 1'b0; flush = 1'b0; funct = 2'b00;
        op1 = '0; op2 = '0; op1_64 = '0; op2_64 = '0;
        #1;
        chk("reset ce", 64'(ce_2), 64'h0);
        chk("reset res", 64'(res_2), 64'h0);
        chk("reset busy", 64'(busy_2), 64'h0);
        chk("reset x64 res", res_x, 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_vec("mul 7x6", 2'b00, 32'h7, 32'h6, 64'h7, 64'h6, 32'h2A, 64'h2A);
        run_vec("mulh -1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, '1, '1, 32'h0, 64'h0);
        run_vec("mulhu -1", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, '1, '1,
                32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE);
        run_vec("mulhsu -1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, '1, '1,
                32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
        run_vec("mul -1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, '1, '1, 32'h1, 64'h1);
        run_vec("mulh min", 2'b01, 32'h80000000, 32'h80000000,
                64'h80000000_00000000, 64'h80000000_00000000, 32'h40000000, 64'h40000000_00000000);
        run_vec("mul min", 2'b00, 32'h80000000, 32'h80000000,
                64'h80000000_00000000, 64'h80000000_00000000, 32'h0, 64'h0);
        run_vec("mulhsu min", 2'b10, 32'h80000000, 32'h80000000,
                64'h80000000_00000000, 64'h80000000_00000000, 32'hC0000000, 64'hC0000000_00000000);

        // Back-to-back with a two-cycle stall; C is re-presented after release.
        funct = 2'b00;
        got_q.delete();
        cyc(1'b1, 32'd2, 32'd3, 1'b0, 1'b0);
        cyc(1'b1, 32'd4, 32'd5, 1'b0, 1'b0);
        chk("stall hold ce c2", 64'(ce_2), 64'h1);
        chk("stall hold res c2", 64'(res_2), 64'd6);
        cyc(1'b1, 32'd6, 32'd7, 1'b1, 1'b0);
        chk("stall hold ce c3", 64'(ce_2), 64'h1);
        chk("stall hold res c3", 64'(res_2), 64'd6);
        cyc(1'b1, 32'd6, 32'd7, 1'b1, 1'b0);
        cyc(1'b1, 32'd6, 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("stream count", 64'(got_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] g;
            logic [31:0] e;
            g = (i < got_q.size()) ? got_q[i] : 32'hxxxxxxxx;
            e = (i == 0) ? 32'd6 : (i == 1) ? 32'd20 : 32'd42;
            chk($sformatf("stream[%0d]", i), 64'(g), 64'(e));
        end

        // Flush with two ops in flight (A in stage 1, B issuing).
        ce = 1'b1; op1 = 32'd3; op2 = 32'd3;
        tick();
        op1 = 32'd5; op2 = 32'd5; flush = 1'b1;
        chk("flush pre busy", 64'(busy_2), 64'h1);
        tick();
        flush = 1'b0;
        chk("flush ce c2", 64'(ce_2), 64'h0);
        chk("flush busy c2", 64'(busy_2), 64'h0);
        op1 = 32'd9; op2 = 32'd9;
        tick();
        ce = 1'b0;
        chk("flush ce c3", 64'(ce_2), 64'h0);
        tick();
        chk("post-flush ce", 64'(ce_2), 64'h1);
        chk("post-flush res", 64'(res_2), 64'd81);
        tick();
        chk("post-flush ce end", 64'(ce_2), 64'h0);

        // Flush wins over stall.
        ce = 1'b1; op1 = 32'd11; op2 = 32'd11;
        tick();
        ce = 1'b0; stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        chk("flush+stall busy", 64'(busy_2), 64'h0);
        chk("flush+stall ce", 64'(ce_2), 64'h0);
        tick();
        chk("flush+stall ce next", 64'(ce_2), 64'h0);
        for (int i = 0; i < 6; i++) tick();

        // Async reset between edges while a result is on the output.
        ce = 1'b1; op1 = 32'd7; op2 = 32'd6; op1_64 = 64'd7; op2_64 = 64'd6;
        tick();
        ce = 1'b0;
        tick();
        chk("pre-rst ce", 64'(ce_2), 64'h1);
        chk("pre-rst res", 64'(res_2), 64'h2A);
        #2 rst = 1'b1;
        #1;
        chk("async rst ce", 64'(ce_2), 64'h0);
        chk("async rst res", 64'(res_2), 64'h0);
        chk("async rst busy", 64'(busy_2), 64'h0);
        chk("async rst s1 res", 64'(res_1), 64'h0);
        chk("async rst s4 busy", 64'(busy_4), 64'h0);
        chk("async rst x64 res", res_x, 64'h0);
        #3 rst = 1'b0;
        tick();
        chk("post-rst ce", 64'(ce_2), 64'h0);
        chk("post-rst busy", 64'(busy_2), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
